// File: rtl/inst_mem_fetch_if.sv
// Fetch-side bus between the IF stage and the instruction memory: program-load
// port, request/response handshake, flush and the consumed-fetch counter.
interface inst_mem_fetch_if #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
);
    logic                  prog_we;
    logic [DEPTH_LOG2-1:0] prog_addr;
    logic [XLEN-1:0]       prog_data;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [XLEN-1:0]       rsp_data;
    logic                  rsp_fault;
    logic                  flush;
    logic [CNT_W-1:0]      fetch_count;

    modport master (
        output prog_we, prog_addr, prog_data, req_valid, req_addr, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, fetch_count
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, req_valid, req_addr, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_data, rsp_fault, fetch_count
    );
endinterface

// File: rtl/inst_mem_fetch.sv
// Instruction memory with program-load port, registered fetch response behind a
// valid/ready handshake, fault flagging, flush and a saturating fetch counter.
module inst_mem_fetch #(
    parameter int             XLEN       = 32,
    parameter int             DEPTH_LOG2 = 6,
    parameter int             ADDR_W     = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000033,
    parameter int             CNT_W      = 16
) (
    input logic             clk,
    input logic             rst,
    inst_mem_fetch_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [XLEN-1:0] mem_q [DEPTH] = '{default: NOP_INSTR};

    logic                  rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]       rsp_data_q,  rsp_data_d;
    logic                  rsp_fault_q, rsp_fault_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;

    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic [XLEN-1:0]       rd_word;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_ready;
    logic                  accept;
    logic                  consume;

    // NOTE: the storage array has no reset branch; its contents must survive rst,
    // and leaving it out keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    // High address bits are checked rather than truncated, so indices never wrap.
    assign fetch_idx    = bus.req_addr[DEPTH_LOG2+1:2];
    assign misaligned   = |bus.req_addr[1:0];
    assign out_of_range = |bus.req_addr[ADDR_W-1:DEPTH_LOG2+2];

    // Write-first: a program write to the word being fetched is forwarded.
    assign rd_word = (bus.prog_we && (bus.prog_addr == fetch_idx)) ? bus.prog_data
                                                                   : mem_q[fetch_idx];

    assign req_ready = !bus.flush && (!rsp_valid_q || bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;
    assign consume   = rsp_valid_q && bus.rsp_ready && !bus.flush;

    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        cnt_d       = cnt_q;

        if (bus.flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = misaligned || out_of_range;
            rsp_data_d  = (misaligned || out_of_range) ? NOP_INSTR : rd_word;
        end else if (consume) begin
            rsp_valid_d = 1'b0;
        end

        if (consume && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= NOP_INSTR;
            rsp_fault_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_fault   = rsp_fault_q;
    assign bus.fetch_count = cnt_q;
endmodule

// File: doc/inst_mem_fetch.md
Name: inst_mem_fetch

Overview:
- Parametrised instruction memory for the pipelined RISC-V core, replacing the fixed 64-word combinational ROM.
- Adds a program-load write port, a registered read with a valid/ready handshake to the IF stage, and a flush input.
- Also adds fault flagging for misaligned or out-of-range fetches, plus a saturating fetch counter.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
- XLEN, 32, instruction word width in bits.
- DEPTH_LOG2, 6, log2 of memory depth in words (default 64 words).
- ADDR_W, 32, width of the byte address from the PC.
- NOP_INSTR, 32'h00000033, word returned on fault or after reset (add x0,x0,x0).
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  program-load write enable.
- prog_addr  in  DEPTH_LOG2  word index for program load.
- prog_data  in  XLEN  instruction word to write.
- req_valid  in  1  IF stage presents a fetch address.
- req_ready  out  1  block accepts the request this cycle.
- req_addr  in  ADDR_W  byte address (PC).
- rsp_valid  out  1  rsp_data/rsp_fault hold a fetched result.
- rsp_ready  in  1  IF/ID consumes the response (low = stall).
- rsp_data  out  XLEN  fetched instruction.
- rsp_fault  out  1  fetch was misaligned or out of range.
- flush  in  1  discard the pending response (branch taken / redirect).
- fetch_count  out  CNT_W  number of responses consumed, saturating.

Behaviour:
- Reset: one clock; rst asynchronous, active-high.
  - On rst: rsp_valid=0, rsp_data=NOP_INSTR, rsp_fault=0, fetch_count=0.
  - Memory contents are not cleared by reset.
  - Reset mid-transaction drops any pending response; no ghost response after rst deasserts.
- Storage:
  - 2**DEPTH_LOG2 words of XLEN.
  - All words are initialised to NOP_INSTR at time zero.
- Program write:
  - On a clk edge with prog_we=1: mem[prog_addr] <= prog_data.
  - Independent of the fetch handshake.
- Handshake:
  - req_ready = !flush && (!rsp_valid || rsp_ready).
  - Accept = req_valid && req_ready.
- Latency:
  - A request accepted at edge N produces rsp_valid=1 after edge N, visible in cycle N+1.
  - One response per cycle is sustained when rsp_ready stays high.
- Response register update, per edge, highest priority first:
  - flush=1: rsp_valid<=0; no accept; rsp_data/rsp_fault hold.
  - accept: rsp_valid<=1, load rsp_data/rsp_fault.
  - rsp_valid && rsp_ready with no accept: rsp_valid<=0.
  - Otherwise (stall): all response outputs hold stable.
- Fault rules:
  - Misaligned when req_addr[1:0]!=0.
  - Out of range when req_addr[ADDR_W-1:DEPTH_LOG2+2] != 0.
  - On fault: rsp_fault=1, rsp_data=NOP_INSTR.
  - Otherwise: rsp_fault=0, rsp_data=mem[req_addr[DEPTH_LOG2+1:2]].
- Same-word collision: if prog_we writes the word being fetched on the accept edge, the response carries the new prog_data (write-first forwarding).
- fetch_count:
  - Increments on each edge with rsp_valid && rsp_ready && !flush.
  - Saturates at all-ones; no wrap.
- Flush and rsp_ready together: flush wins; the response is discarded and not counted.
- Word-index wrap is impossible: high address bits are checked, not truncated.

Test Plan:
- Load mem[1]=32'h00002083 via prog_we; assert rst then release; req_addr=4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=32'h00002083, rsp_fault=0, fetch_count=1 after consume.
- Back-to-back fetches 0,4,8,12 with rsp_ready=1 -> 4 consecutive valid responses, req_ready constantly 1, fetch_count=4.
- Stall:
  - Fetch addr 8, then hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp_data stable for 3 cycles.
  - Release -> next address accepted the same cycle.
- Faults:
  - req_addr=6 -> rsp_fault=1, rsp_data=32'h00000033.
  - req_addr=256 (DEPTH_LOG2=6) -> rsp_fault=1, rsp_data=32'h00000033.
- Flush: assert flush while rsp_valid=1 and rsp_ready=1 -> rsp_valid=0 next cycle, req_ready=0 during flush, fetch_count unchanged.
- Collision and reset:
  - prog_we to word 3 with 32'h00A00093 on the same edge as fetch of addr 12 -> rsp_data=32'h00A00093.
  - Pulse rst asynchronously between edges -> rsp_valid drops immediately, fetch_count=0, mem[3] retained.
